mc_control_fsm: RTL and testbench

- Moore-style multicycle controller that sequences the single-ALU MIPS datapath.
- Drives every write-enable and mux select of the datapath, including the 3-bit ALU-B operand select (mux_B), the PC source and the memory address source.
- Decodes opcode/funct from the instruction register.
- Inserts memory wait cycles; optionally handles arithmetic-overflow exceptions.
- Sits between the instruction register and the datapath top.

---
 rtl/mc_control_fsm.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Moore multicycle controller sequencing the single-ALU MIPS datapath.
// Define OVERFLOW_EXC_EN to add the overflow / undefined-opcode EXC state.
module mc_control_fsm #(
    parameter int unsigned MEM_WAIT       = 2,
    parameter logic [1:0]  EXC_VECTOR_SEL = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       a_wr,
    output logic       b_wr,
    output logic       alu_out_wr,
    output logic       alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       epc_wr,
    output logic [4:0] state_dbg
);

    typedef enum logic [4:0] {
        S_RESET     = 5'd0,
        S_FETCH     = 5'd1,
        S_FETCH_LD  = 5'd2,
        S_DECODE    = 5'd3,
        S_R_EXEC    = 5'd4,
        S_R_WB      = 5'd5,
        S_ADDI_EXEC = 5'd6,
        S_I_WB      = 5'd7,
        S_ADDR      = 5'd8,
        S_LW_RD     = 5'd9,
        S_LW_WB     = 5'd10,
        S_SW_WR     = 5'd11,
        S_BEQ       = 5'd12,
        S_BNE       = 5'd13,
        S_JUMP      = 5'd14,
        S_JR        = 5'd15
`ifdef OVERFLOW_EXC_EN
        , S_EXC     = 5'd16
`endif
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       a_wr;
        logic       b_wr;
        logic       alu_out_wr;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       epc_wr;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    localparam logic [2:0] WAIT_N = 3'(MEM_WAIT);

`ifdef OVERFLOW_EXC_EN
    localparam state_t S_BAD = S_EXC;
`else
    localparam state_t S_BAD = S_FETCH;
`endif

    state_t     state;
    state_t     ns;
    logic [2:0] cnt;
    ctl_t       ctl;
    ctl_t       nc;
    logic       r_arith;

    assign r_arith = (funct == FN_ADD) || (funct == FN_SUB) ||
                     (funct == FN_AND);

    always_comb begin
        ns = state;
        case (state)
            S_RESET:    ns = S_FETCH;
            S_FETCH:    if (cnt == WAIT_N) ns = S_FETCH_LD;
            S_FETCH_LD: ns = S_DECODE;
            S_DECODE: begin
                ns = S_BAD;
                case (opcode)
                    OP_RTYPE: begin
                        if (r_arith) ns = S_R_EXEC;
                        else if (funct == FN_JR) ns = S_JR;
                    end
                    OP_ADDI: ns = S_ADDI_EXEC;
                    OP_LW,
                    OP_SW:   ns = S_ADDR;
                    OP_BEQ:  ns = S_BEQ;
                    OP_BNE:  ns = S_BNE;
                    OP_J:    ns = S_JUMP;
                    default: ns = S_BAD;
                endcase
            end
            S_R_EXEC: begin
                ns = S_R_WB;
`ifdef OVERFLOW_EXC_EN
                // and never overflows; only add/sub trap
                if (overflow && funct != FN_AND) ns = S_EXC;
`endif
            end
            S_ADDI_EXEC: begin
                ns = S_I_WB;
`ifdef OVERFLOW_EXC_EN
                if (overflow) ns = S_EXC;
`endif
            end
            S_ADDR:  ns = (opcode == OP_SW) ? S_SW_WR : S_LW_RD;
            S_LW_RD: if (cnt == WAIT_N) ns = S_LW_WB;
            default: ns = S_FETCH;
        endcase
    end

    // Outputs are decoded from the next state and registered with it,
    // so they remain a pure function of the current state.
    always_comb begin
        nc = '0;
        case (ns)
            S_FETCH: begin
                nc.alu_src_b = 3'b001;
                nc.alu_op    = 3'b001;
            end
            S_FETCH_LD: begin
                nc.alu_src_b = 3'b001;
                nc.alu_op    = 3'b001;
                nc.ir_wr     = 1'b1;
                nc.pc_write  = 1'b1;
            end
            S_DECODE: begin
                nc.a_wr       = 1'b1;
                nc.b_wr       = 1'b1;
                nc.alu_src_b  = 3'b011;
                nc.alu_op     = 3'b001;
                nc.alu_out_wr = 1'b1;
            end
            S_R_EXEC: begin
                nc.alu_src_a  = 1'b1;
                nc.alu_out_wr = 1'b1;
                case (funct)
                    FN_SUB:  nc.alu_op = 3'b010;
                    FN_AND:  nc.alu_op = 3'b011;
                    default: nc.alu_op = 3'b001;
                endcase
            end
            S_R_WB: begin
                nc.reg_wr  = 1'b1;
                nc.reg_dst = 1'b1;
            end
            S_ADDI_EXEC, S_ADDR: begin
                nc.alu_src_a  = 1'b1;
                nc.alu_src_b  = 3'b010;
                nc.alu_op     = 3'b001;
                nc.alu_out_wr = 1'b1;
            end
            S_I_WB:  nc.reg_wr = 1'b1;
            S_LW_RD: nc.i_or_d = 1'b1;
            S_LW_WB: begin
                nc.reg_wr     = 1'b1;
                nc.mem_to_reg = 1'b1;
            end
            S_SW_WR: begin
                nc.i_or_d = 1'b1;
                nc.mem_wr = 1'b1;
            end
            S_BEQ, S_BNE: begin
                nc.alu_src_a     = 1'b1;
                nc.alu_op        = 3'b010;
                nc.pc_write_cond = 1'b1;
                nc.pc_source     = 2'b01;
                nc.branch_ne     = (ns == S_BNE);
            end
            S_JUMP: begin
                nc.pc_write  = 1'b1;
                nc.pc_source = 2'b10;
            end
            S_JR: begin
                nc.pc_write  = 1'b1;
                nc.alu_src_a = 1'b1;
            end
`ifdef OVERFLOW_EXC_EN
            S_EXC: begin
                nc.epc_wr    = 1'b1;
                nc.alu_src_b = 3'b001;
                nc.alu_op    = 3'b010;
                nc.pc_write  = 1'b1;
                nc.pc_source = EXC_VECTOR_SEL;
            end
`endif
            default: nc = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RESET;
            cnt   <= '0;
            ctl   <= '0;
        end else begin
            state <= ns;
            cnt   <= (ns != state) ? 3'd0 : cnt + 3'd1;
            ctl   <= nc;
        end
    end

    // zero is consumed by the datapath branch gate, not by sequencing
    logic unused_in;
    assign unused_in = &{1'b0, zero, overflow};

    assign pc_write      = ctl.pc_write;
    assign pc_write_cond = ctl.pc_write_cond;
    assign branch_ne     = ctl.branch_ne;
    assign i_or_d        = ctl.i_or_d;
    assign mem_wr        = ctl.mem_wr;
    assign ir_wr         = ctl.ir_wr;
    assign reg_wr        = ctl.reg_wr;
    assign reg_dst       = ctl.reg_dst;
    assign mem_to_reg    = ctl.mem_to_reg;
    assign a_wr          = ctl.a_wr;
    assign b_wr          = ctl.b_wr;
    assign alu_out_wr    = ctl.alu_out_wr;
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign alu_op        = ctl.alu_op;
    assign pc_source     = ctl.pc_source;
    assign epc_wr        = ctl.epc_wr;
    assign state_dbg     = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed, table-driven bench for mc_control_fsm (MEM_WAIT=2 main DUT,
// MEM_WAIT=0 second DUT for the zero-wait boundary).
module tb_mc_control_fsm;

    localparam int M = 2;

    localparam logic [4:0] ST_RESET = 5'd0;
    localparam logic [4:0] ST_FETCH = 5'd1;
    localparam logic [4:0] ST_FLD   = 5'd2;
    localparam logic [4:0] ST_DEC   = 5'd3;
    localparam logic [4:0] ST_REX   = 5'd4;
    localparam logic [4:0] ST_RWB   = 5'd5;
    localparam logic [4:0] ST_AEX   = 5'd6;
    localparam logic [4:0] ST_IWB   = 5'd7;
    localparam logic [4:0] ST_ADDR  = 5'd8;
    localparam logic [4:0] ST_LWRD  = 5'd9;
    localparam logic [4:0] ST_LWWB  = 5'd10;
    localparam logic [4:0] ST_SW    = 5'd11;
    localparam logic [4:0] ST_BEQ   = 5'd12;
    localparam logic [4:0] ST_BNE   = 5'd13;
    localparam logic [4:0] ST_J     = 5'd14;
    localparam logic [4:0] ST_JR    = 5'd15;
    localparam logic [4:0] ST_EXC   = 5'd16;

    // {pcw,pcwc,bne,iord,mw,irw,rw,rd,m2r,aw,bw,aow,sa, srcb, aluop, pcsrc, epc}
    localparam logic [21:0] O_ZERO = '0;
    localparam logic [21:0] O_FETCH =
        {13'b0000000000000, 3'b001, 3'b001, 2'b00, 1'b0};
    localparam logic [21:0] O_FLD =
        {13'b1000010000000, 3'b001, 3'b001, 2'b00, 1'b0};
    localparam logic [21:0] O_DEC =
        {13'b0000000001110, 3'b011, 3'b001, 2'b00, 1'b0};
    localparam logic [21:0] O_RADD =
        {13'b0000000000011, 3'b000, 3'b001, 2'b00, 1'b0};
    localparam logic [21:0] O_RSUB =
        {13'b0000000000011, 3'b000, 3'b010, 2'b00, 1'b0};
    localparam logic [21:0] O_RAND =
        {13'b0000000000011, 3'b000, 3'b011, 2'b00, 1'b0};
    localparam logic [21:0] O_RWB =
        {13'b0000001100000, 3'b000, 3'b000, 2'b00, 1'b0};
    localparam logic [21:0] O_ADDI =
        {13'b0000000000011, 3'b010, 3'b001, 2'b00, 1'b0};
    localparam logic [21:0] O_IWB =
        {13'b0000001000000, 3'b000, 3'b000, 2'b00, 1'b0};
    localparam logic [21:0] O_LWRD =
        {13'b0001000000000, 3'b000, 3'b000, 2'b00, 1'b0};
    localparam logic [21:0] O_LWWB =
        {13'b0000001010000, 3'b000, 3'b000, 2'b00, 1'b0};
    localparam logic [21:0] O_SW =
        {13'b0001100000000, 3'b000, 3'b000, 2'b00, 1'b0};
    localparam logic [21:0] O_BEQ =
        {13'b0100000000001, 3'b000, 3'b010, 2'b01, 1'b0};
    localparam logic [21:0] O_BNE =
        {13'b0110000000001, 3'b000, 3'b010, 2'b01, 1'b0};
    localparam logic [21:0] O_J =
        {13'b1000000000000, 3'b000, 3'b000, 2'b10, 1'b0};
    localparam logic [21:0] O_JR =
        {13'b1000000000001, 3'b000, 3'b000, 2'b00, 1'b0};
    localparam logic [21:0] O_EXC =
        {13'b1000000000000, 3'b001, 3'b010, 2'b11, 1'b1};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        ov;
        logic [4:0]  st;
        logic [21:0] o;
        string       name;
    } vec_t;

    vec_t vecs[$];

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;

    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_wr, ir_wr;
    logic       reg_wr, reg_dst, mem_to_reg, a_wr, b_wr, alu_out_wr;
    logic       alu_src_a, epc_wr;
    logic [2:0] alu_src_b, alu_op;
    logic [1:0] pc_source;
    logic [4:0] state_dbg;

    logic       pcw0, pcwc0, bne0, iord0, mw0, irw0;
    logic       rw0, rd0, m2r0, aw0, bw0, aow0, sa0, epc0;
    logic [2:0] srcb0, aluop0;
    logic [1:0] pcs0;
    logic [4:0] st0;

    int errors = 0;
    int checks = 0;
    bit epc_seen = 1'b0;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_WAIT(M), .EXC_VECTOR_SEL(2'b11)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .i_or_d(i_or_d), .mem_wr(mem_wr),
        .ir_wr(ir_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .a_wr(a_wr), .b_wr(b_wr),
        .alu_out_wr(alu_out_wr), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .epc_wr(epc_wr), .state_dbg(state_dbg)
    );

    mc_control_fsm #(.MEM_WAIT(0), .EXC_VECTOR_SEL(2'b11)) u_dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow),
        .pc_write(pcw0), .pc_write_cond(pcwc0), .branch_ne(bne0),
        .i_or_d(iord0), .mem_wr(mw0), .ir_wr(irw0), .reg_wr(rw0),
        .reg_dst(rd0), .mem_to_reg(m2r0), .a_wr(aw0), .b_wr(bw0),
        .alu_out_wr(aow0), .alu_src_a(sa0), .alu_src_b(srcb0),
        .alu_op(aluop0), .pc_source(pcs0), .epc_wr(epc0),
        .state_dbg(st0)
    );

    logic [21:0] outv;
    logic [21:0] outv0;
    assign outv = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_wr,
                   ir_wr, reg_wr, reg_dst, mem_to_reg, a_wr, b_wr,
                   alu_out_wr, alu_src_a, alu_src_b, alu_op, pc_source,
                   epc_wr};
    assign outv0 = {pcw0, pcwc0, bne0, iord0, mw0, irw0, rw0, rd0, m2r0,
                    aw0, bw0, aow0, sa0, srcb0, aluop0, pcs0, epc0};

    always @(negedge clk) if (epc_wr === 1'b1) epc_seen = 1'b1;

    task automatic chk(input string name, input logic [26:0] act,
                       input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic ov,
                                 input logic [4:0] st, input logic [21:0] o,
                                 input string name);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.ov = ov;
        v.st = st; v.o = o; v.name = name;
        vecs.push_back(v);
    endfunction

    function automatic void fetch(input logic [5:0] op, input logic [5:0] fn,
                                  input logic z, input logic ov,
                                  input string name);
        for (int i = 0; i <= M; i++)
            push(op, fn, z, ov, ST_FETCH, O_FETCH, {name, "_fetch"});
        push(op, fn, z, ov, ST_FLD, O_FLD, {name, "_fld"});
        push(op, fn, z, ov, ST_DEC, O_DEC, {name, "_dec"});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rw_cnt;
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;

        // add, sub, and(with overflow, never traps)
        fetch(6'h00, 6'h20, 0, 0, "add");
        push(6'h00, 6'h20, 0, 0, ST_REX, O_RADD, "add_exec");
        push(6'h00, 6'h20, 0, 0, ST_RWB, O_RWB, "add_wb");
        fetch(6'h00, 6'h22, 0, 0, "sub");
        push(6'h00, 6'h22, 0, 0, ST_REX, O_RSUB, "sub_exec");
        push(6'h00, 6'h22, 0, 0, ST_RWB, O_RWB, "sub_wb");
        fetch(6'h00, 6'h24, 0, 1, "and");
        push(6'h00, 6'h24, 0, 1, ST_REX, O_RAND, "and_exec");
        push(6'h00, 6'h24, 0, 1, ST_RWB, O_RWB, "and_wb");
        // lw then sw
        fetch(6'h23, 6'h00, 0, 0, "lw");
        push(6'h23, 6'h00, 0, 0, ST_ADDR, O_ADDI, "lw_addr");
        for (int i = 0; i <= M; i++)
            push(6'h23, 6'h00, 0, 0, ST_LWRD, O_LWRD, "lw_rd");
        push(6'h23, 6'h00, 0, 0, ST_LWWB, O_LWWB, "lw_wb");
        fetch(6'h2B, 6'h00, 0, 0, "sw");
        push(6'h2B, 6'h00, 0, 0, ST_ADDR, O_ADDI, "sw_addr");
        push(6'h2B, 6'h00, 0, 0, ST_SW, O_SW, "sw_wr");
        // branches and jumps
        fetch(6'h04, 6'h00, 1, 0, "beq");
        push(6'h04, 6'h00, 1, 0, ST_BEQ, O_BEQ, "beq");
        fetch(6'h05, 6'h00, 1, 0, "bne");
        push(6'h05, 6'h00, 1, 0, ST_BNE, O_BNE, "bne");
        fetch(6'h02, 6'h00, 0, 0, "j");
        push(6'h02, 6'h00, 0, 0, ST_J, O_J, "j");
        fetch(6'h00, 6'h08, 0, 0, "jr");
        push(6'h00, 6'h08, 0, 0, ST_JR, O_JR, "jr");
        // addi without and with overflow, add with overflow
        fetch(6'h08, 6'h00, 0, 0, "addi");
        push(6'h08, 6'h00, 0, 0, ST_AEX, O_ADDI, "addi_exec");
        push(6'h08, 6'h00, 0, 0, ST_IWB, O_IWB, "addi_wb");
        fetch(6'h08, 6'h00, 0, 1, "addi_ov");
        push(6'h08, 6'h00, 0, 1, ST_AEX, O_ADDI, "addi_ov_exec");
`ifdef OVERFLOW_EXC_EN
        push(6'h08, 6'h00, 0, 1, ST_EXC, O_EXC, "addi_ov_exc");
`else
        push(6'h08, 6'h00, 0, 1, ST_IWB, O_IWB, "addi_ov_wb");
`endif
        fetch(6'h00, 6'h20, 0, 1, "add_ov");
        push(6'h00, 6'h20, 0, 1, ST_REX, O_RADD, "add_ov_exec");
`ifdef OVERFLOW_EXC_EN
        push(6'h00, 6'h20, 0, 1, ST_EXC, O_EXC, "add_ov_exc");
`else
        push(6'h00, 6'h20, 0, 1, ST_RWB, O_RWB, "add_ov_wb");
`endif
        // undefined opcode last, followed by a complete refetch
        fetch(6'h3F, 6'h00, 0, 0, "undef");
`ifdef OVERFLOW_EXC_EN
        push(6'h3F, 6'h00, 0, 0, ST_EXC, O_EXC, "undef_exc");
`endif
        for (int i = 0; i <= M; i++)
            push(6'h3F, 6'h00, 0, 0, ST_FETCH, O_FETCH, "undef_refetch");
        push(6'h3F, 6'h00, 0, 0, ST_FLD, O_FLD, "undef_fld");

        // reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_hold", {state_dbg, outv}, {ST_RESET, O_ZERO});
            chk("reset_hold_m0", {st0, outv0}, {ST_RESET, O_ZERO});
        end
        reset = 1'b0;

        foreach (vecs[i]) begin
            opcode = vecs[i].op; funct = vecs[i].fn;
            zero = vecs[i].z; overflow = vecs[i].ov;
            @(posedge clk); #1;
            chk($sformatf("%s[%0d]", vecs[i].name, i), {state_dbg, outv},
                {vecs[i].st, vecs[i].o});
        end

        // asynchronous reset during LW_RD
        reset = 1'b1; opcode = 6'h23; funct = '0; zero = 0; overflow = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (M + 5) @(posedge clk);
        #1;
        chk("lw_rd_reached", {state_dbg, outv}, {ST_LWRD, O_LWRD});
        #2 reset = 1'b1;
        #1;
        chk("async_abort", {state_dbg, outv}, {ST_RESET, O_ZERO});
        @(posedge clk); #1;
        reset = 1'b0;
        rw_cnt = 0;
        @(posedge clk); #1;
        chk("restart_fetch", {state_dbg, outv}, {ST_FETCH, O_FETCH});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (reg_wr === 1'b1) rw_cnt++;
        end
        chk("no_reg_wr_after_abort", 27'(rw_cnt), 27'd0);

        // MEM_WAIT=0: FETCH and LW_RD last one cycle each (lw = 6 cycles)
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("m0_fetch", {st0, outv0}, {ST_FETCH, O_FETCH});
        @(posedge clk); #1;
        chk("m0_fld", {st0, outv0}, {ST_FLD, O_FLD});
        @(posedge clk); #1;
        chk("m0_dec", {st0, outv0}, {ST_DEC, O_DEC});
        @(posedge clk); #1;
        chk("m0_addr", {st0, outv0}, {ST_ADDR, O_ADDI});
        @(posedge clk); #1;
        chk("m0_lwrd", {st0, outv0}, {ST_LWRD, O_LWRD});
        @(posedge clk); #1;
        chk("m0_lwwb", {st0, outv0}, {ST_LWWB, O_LWWB});
        @(posedge clk); #1;
        chk("m0_refetch", {st0, outv0}, {ST_FETCH, O_FETCH});

`ifndef OVERFLOW_EXC_EN
        chk("epc_never_set", {26'd0, epc_seen}, 27'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
